// File: rtl/cpc_mem_pkg.sv
// Shared memory-side types and constants for the cache/memory path.
// Holds bus width defaults, the memory-mapped I/O addresses, and the arbiter state and owner enums.
package cpc_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int BLK_W  = 256;

    localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'hF000_0004;

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets the icache and dcache share one memory port. A request is served in memory latency + 2 cycles.
// Requesters hold their request until their ack pulse. Memory stalls the winner by holding ackm_n high.
module mem_arbiter #(
    parameter int ADDR_W = cpc_mem_pkg::ADDR_W,
    parameter int BLK_W  = cpc_mem_pkg::BLK_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] iad,
    input  logic              imreq,
    output logic [BLK_W-1:0]  idt,
    output logic              acki_n,
    input  logic [ADDR_W-1:0] dad,
    input  logic              dmreq,
    input  logic              dmwrite,
    input  logic [BLK_W-1:0]  dwdt,
    output logic [BLK_W-1:0]  drdt,
    output logic              ackd_n,
    output logic [ADDR_W-1:0] mad,
    output logic              mreq,
    output logic              mwrite,
    output logic [BLK_W-1:0]  mwdt,
    input  logic [BLK_W-1:0]  mrdt,
    input  logic              ackm_n,
    output logic [CNT_W-1:0]  igrant_cnt,
    output logic [CNT_W-1:0]  dgrant_cnt
);
    import cpc_mem_pkg::*;

    state_t state;
    owner_t last;

    // On a tie, the port that was not served last wins.
    function automatic logic pick_d(input logic ireq, input logic dreq, input owner_t prev);
        return dreq && (!ireq || prev == OWN_I);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last       <= OWN_I;
            mreq       <= 1'b0;
            mwrite     <= 1'b0;
            mad        <= '0;
            mwdt       <= '0;
            acki_n     <= 1'b1;
            ackd_n     <= 1'b1;
            idt        <= '0;
            drdt       <= '0;
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
        end else begin
            acki_n <= 1'b1;
            ackd_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_d(imreq, dmreq, last)) begin
                        mad    <= dad;
                        mwrite <= dmwrite;
                        mwdt   <= dwdt;
                        mreq   <= 1'b1;
                        state  <= DBUSY;
                    end else if (imreq) begin
                        mad    <= iad;
                        mwrite <= 1'b0;
                        mreq   <= 1'b1;
                        state  <= IBUSY;
                    end
                end
                IBUSY: begin
                    if (!ackm_n) begin
                        idt    <= mrdt;
                        last   <= OWN_I;
                        acki_n <= 1'b0;
                        mreq   <= 1'b0;
                        if (igrant_cnt != {CNT_W{1'b1}})
                            igrant_cnt <= igrant_cnt + CNT_W'(1);
                        state  <= RESP;
                    end
                end
                DBUSY: begin
                    if (!ackm_n) begin
                        if (!mwrite)
                            drdt <= mrdt;
                        last   <= OWN_D;
                        ackd_n <= 1'b0;
                        mreq   <= 1'b0;
                        mwrite <= 1'b0;
                        if (dgrant_cnt != {CNT_W{1'b1}})
                            dgrant_cnt <= dgrant_cnt + CNT_W'(1);
                        state  <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
